fp_add_seq: RTL and testbench



---
 rtl/fp_add_seq_if.sv | 25 ++
 rtl/fp_add_seq.sv | 180 ++++++++++++++++++
 tb/tb_fp_add_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle for the sequential single-precision adder.
// Both channels use the same valid/ready rule: a transfer happens on a rising
// clk edge where valid and ready are both high; the producer holds valid and
// its payload steady until that edge, and ready never depends on valid.
interface fp_add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;

  // Driving side: supplies operands and consumes the result.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, z
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/fp_add_seq.sv
// Multi-cycle signed single-precision adder z = a + b (truncating, no
// denormals). Alignment and normalization move one bit per cycle.
// Opposite-sign operands become an effective subtract of the smaller
// magnitude from the larger one, so the working sum is never negative.
module fp_add_seq (
  input  logic        clk,
  input  logic        reset,
  fp_add_seq_if.slave bus,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] z_r;

  // Working registers. Mantissa layout: [27] carry, [26] hidden one,
  // [25:3] fraction, [2:0] guard bits that collect the alignment shift.
  logic [27:0] big_m;
  logic [27:0] small_m;
  logic [27:0] sum;
  logic [7:0]  exp_w;
  logic        sign_r;
  logic        sub_r;
  logic [4:0]  cnt;

  // Accept-time decode of the incoming operand pair.
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [27:0] ma;
  logic [27:0] mb;
  logic        a_big;
  logic [7:0]  e_big;
  logic [7:0]  e_small;
  logic [7:0]  diff;
  logic [4:0]  shift_n;
  logic        is_nan;
  logic        a_zero;
  logic        b_zero;

  // Classify operands and pick the larger magnitude (exponent, then fraction).
  always_comb begin
    ea      = bus.a[30:23];
    eb      = bus.b[30:23];
    ma      = {2'b01, bus.a[22:0], 3'b000};
    mb      = {2'b01, bus.b[22:0], 3'b000};
    a_big   = ({ea, bus.a[22:0]} >= {eb, bus.b[22:0]});
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    diff    = e_big - e_small;
    // Beyond 27 shifts the small mantissa is entirely gone anyway.
    shift_n = (diff > 8'd27) ? 5'd27 : diff[4:0];
    is_nan  = (ea == 8'hFF) || (eb == 8'hFF);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
  end

  // Control FSM and datapath; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      z_r         <= 32'h0;
      big_m       <= 28'h0;
      small_m     <= 28'h0;
      sum         <= 28'h0;
      exp_w       <= 8'h0;
      sign_r      <= 1'b0;
      sub_r       <= 1'b0;
      cnt         <= 5'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            if (is_nan) begin
              z_r         <= 32'hFFFF_FFFF;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else if (a_zero && b_zero) begin
              // Signed zeros collapse to +0.
              z_r         <= 32'h0;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else if (a_zero) begin
              z_r         <= bus.b;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else if (b_zero) begin
              z_r         <= bus.a;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              big_m   <= a_big ? ma : mb;
              small_m <= a_big ? mb : ma;
              exp_w   <= e_big;
              sign_r  <= a_big ? bus.a[31] : bus.b[31];
              sub_r   <= bus.a[31] ^ bus.b[31];
              cnt     <= shift_n;
              state   <= (shift_n == 5'd0) ? ADD : ALIGN;
            end
          end
        end

        ALIGN: begin
          // Bits falling off the bottom are discarded.
          small_m <= small_m >> 1;
          cnt     <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= ADD;
          end
        end

        ADD: begin
          sum   <= sub_r ? (big_m - small_m) : (big_m + small_m);
          state <= NORM;
        end

        NORM: begin
          if (sum == 28'h0) begin
            // Exact cancellation always yields +0.
            z_r         <= 32'h0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else if (sum[27]) begin
            if (exp_w == 8'd254) begin
              z_r         <= 32'hFFFF_FFFF;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              sum   <= sum >> 1;
              exp_w <= exp_w + 8'd1;
            end
          end else if (sum[26]) begin
            z_r         <= {sign_r, exp_w, sum[25:3]};
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else if (exp_w == 8'd1) begin
            // One more left shift would need exponent 0: flush to zero.
            z_r         <= 32'h0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            sum   <= sum << 1;
            exp_w <= exp_w - 8'd1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.z         = z_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: directed and random operand pairs with an
// independently written reference model, handshake hold and mid-op reset.
module tb_fp_add_seq;

  logic clk;
  logic reset;
  logic [2:0] state_dbg;

  fp_add_seq_if bus ();

  fp_add_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Reference: result and latency in clk edges after the accept edge
  // (special cases are already in DONE right after the accept edge -> 0).
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] zz, output int lat);
    logic [31:0] big, sml;
    logic [27:0] mbig, msml, s, t;
    int e, d, al, p, k, norm;
    lat = 0;
    zz  = 32'h0;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
      zz = 32'hFFFF_FFFF;
      return;
    end
    if (x[30:23] == 8'h00 && y[30:23] == 8'h00) begin
      zz = 32'h0;
      return;
    end
    if (x[30:23] == 8'h00) begin
      zz = y;
      return;
    end
    if (y[30:23] == 8'h00) begin
      zz = x;
      return;
    end
    if (x[30:0] >= y[30:0]) begin
      big = x; sml = y;
    end else begin
      big = y; sml = x;
    end
    e    = int'(big[30:23]);
    d    = e - int'(sml[30:23]);
    al   = (d > 27) ? 27 : d;
    mbig = {2'b01, big[22:0], 3'b000};
    msml = {2'b01, sml[22:0], 3'b000} >> al;
    s    = (big[31] != sml[31]) ? (mbig - msml) : (mbig + msml);
    if (s == 28'h0) begin
      zz   = 32'h0;
      norm = 1;
    end else if (s[27]) begin
      norm = (e == 254) ? 1 : 2;
      zz   = (e == 254) ? 32'hFFFF_FFFF : {big[31], 8'(e + 1), s[26:4]};
    end else begin
      p = 0;
      for (int i = 0; i <= 26; i++) if (s[i]) p = i;
      k = 26 - p;
      if (e <= k) begin
        zz   = 32'h0;
        norm = e;
      end else begin
        t    = s << k;
        zz   = {big[31], 8'(e - k), t[25:3]};
        norm = k + 1;
      end
    end
    lat = al + 1 + norm;
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] opa, input logic [31:0] opb);
    logic [31:0] ez;
    int el, n;
    model(opa, opb, ez, el);
    exp_q.push_back(ez);
    lat_q.push_back(el);
    bus.in_valid = 1'b1;
    bus.a = opa;
    bus.b = opb;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard side: wait for the result, pop and compare.
  task automatic collect(input string tag);
    logic [31:0] ez;
    int el, lat;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check({tag, "_timeout"}, 32'd0, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    ez = exp_q.pop_front();
    el = lat_q.pop_front();
    check({tag, "_z"}, bus.z, ez);
    check({tag, "_lat"}, 32'(lat), 32'(el));
    if (bus.out_ready) begin
      @(negedge clk);
      check({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_ir_set"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_z_hold"}, bus.z, ez);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] opa, input logic [31:0] opb);
    issue(opa, opb);
    collect(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] dir_a[14] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F800000,
                             32'h00000000, 32'h7F7FFFFF, 32'h7F800000, 32'h00800001,
                             32'h3F800000, 32'h3F800000, 32'h80000000, 32'hC1200000,
                             32'h3F800000, 32'h42C80000};
  logic [31:0] dir_b[14] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'hBF800000,
                             32'hC0400000, 32'h7F7FFFFF, 32'h3F800000, 32'h80800000,
                             32'h33800000, 32'h00800000, 32'h00000000, 32'h41200001,
                             32'h3FFFFFFF, 32'hC2C7FFFF};

  initial begin
    logic [31:0] ra, rb;
    int ea, eb;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_z", bus.z, 32'h0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases, back-to-back: each accept lands on the edge after
    // the previous output handshake.
    for (int i = 0; i < 14; i++) begin
      run($sformatf("dir%0d", i), dir_a[i], dir_b[i]);
    end

    // Random operands, exponents kept close enough to exercise alignment.
    for (int i = 0; i < 40; i++) begin
      ea = $urandom_range(1, 254);
      eb = ea + $urandom_range(0, 30) - 15;
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      if (i % 10 == 3) eb = 0;
      if (i % 10 == 7) eb = 255;
      ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if (i % 5 == 1) rb = {~ra[31], ra[30:0]};
      run($sformatf("rnd%0d", i), ra, rb);
    end

    // Output back-pressure: result and flags hold, new operands ignored.
    bus.out_ready = 1'b0;
    issue(32'h3F800000, 32'h40000000);
    collect("hold");
    bus.in_valid = 1'b1;
    bus.a = 32'h40400000;
    bus.b = 32'h40400000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_z", bus.z, 32'h40400000);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_z", bus.z, 32'h40400000);
    @(negedge clk);
    check("ignored_state", 32'(state_dbg), 32'd0);
    check("ignored_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a long alignment.
    issue(32'h3F800000, 32'h00800000);
    repeat (3) @(negedge clk);
    check("align_state", 32'(state_dbg), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_z", bus.z, 32'h0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check("abort_hold_out_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_post_in_ready", 32'(bus.in_ready), 32'd1);
    run("after_abort", 32'h3F800000, 32'h3F800000);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
